// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU operation/class codes and divider state encoding for the EX stage.
package ex_stage_pkg;

    localparam int unsigned ALU_OP_W   = 8;
    localparam int unsigned ALU_SEL_W  = 3;
    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [ALU_OP_W-1:0] OP_NOP  = 8'b0000_0000;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 8'b0010_0100;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 8'b0010_0101;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 8'b0010_0110;
    localparam logic [ALU_OP_W-1:0] OP_NOR  = 8'b0010_0111;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 8'b0111_1100;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 8'b0000_0010;
    localparam logic [ALU_OP_W-1:0] OP_SRA  = 8'b0000_0011;
    localparam logic [ALU_OP_W-1:0] OP_ADDU = 8'b0010_0001;
    localparam logic [ALU_OP_W-1:0] OP_SUBU = 8'b0010_0011;
    localparam logic [ALU_OP_W-1:0] OP_SLT  = 8'b0010_1010;
    localparam logic [ALU_OP_W-1:0] OP_SLTU = 8'b0010_1011;
    localparam logic [ALU_OP_W-1:0] OP_DIV  = 8'b0001_1010;
    localparam logic [ALU_OP_W-1:0] OP_DIVU = 8'b0001_1011;

    localparam logic [ALU_SEL_W-1:0] SEL_NOP   = 3'b000;
    localparam logic [ALU_SEL_W-1:0] SEL_LOGIC = 3'b001;
    localparam logic [ALU_SEL_W-1:0] SEL_SHIFT = 3'b010;
    localparam logic [ALU_SEL_W-1:0] SEL_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10,
        DIV_ZERO = 2'b11
    } div_state_e;

    function automatic logic [REG_W-1:0] magnitude(input logic [REG_W-1:0] v, input logic is_signed);
        return (is_signed && v[REG_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes, signs fixed up on output.
module div
    import ex_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [REG_W-1:0]     opdata1,
    input  logic [REG_W-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*REG_W-1:0]   result,
    output logic                 ready
);

    div_state_e       state, next_state;
    logic [5:0]       cnt;
    logic [REG_W-1:0] rem, quo, dvs;
    logic             neg_q, neg_r;

    logic [REG_W:0]   shifted;
    logic [REG_W-1:0] trial;
    logic             fits;

    always_comb begin
        shifted = {rem, quo[REG_W-1]};
        trial   = shifted[REG_W-1:0] - dvs;
        fits    = shifted >= {1'b0, dvs};
    end

    always_comb begin
        next_state = state;
        unique case (state)
            DIV_IDLE: if (start) next_state = (opdata2 == '0) ? DIV_ZERO : DIV_BUSY;
            DIV_BUSY: if (cnt == 6'd31) next_state = DIV_DONE;
            DIV_DONE: next_state = DIV_IDLE;
            DIV_ZERO: next_state = DIV_IDLE;
            default:  next_state = DIV_IDLE;
        endcase
        if (annul) next_state = DIV_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DIV_IDLE && next_state == DIV_BUSY) begin
                quo   <= magnitude(opdata1, signed_div);
                dvs   <= magnitude(opdata2, signed_div);
                rem   <= '0;
                cnt   <= '0;
                neg_q <= signed_div && (opdata1[REG_W-1] ^ opdata2[REG_W-1]);
                neg_r <= signed_div && opdata1[REG_W-1];
            end else if (state == DIV_IDLE && next_state == DIV_ZERO) begin
                // Zero divisor: the raw dividend is parked in quo and returned as HI.
                quo   <= opdata1;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else if (state == DIV_BUSY) begin
                rem <= fits ? trial : shifted[REG_W-1:0];
                quo <= {quo[REG_W-2:0], fits};
                cnt <= cnt + 6'd1;
            end
        end
    end

    always_comb begin
        ready  = 1'b0;
        result = '0;
        if (!annul) begin
            if (state == DIV_DONE) begin
                ready  = 1'b1;
                result = {neg_r ? (~rem + 1'b1) : rem,
                          neg_q ? (~quo + 1'b1) : quo};
            end else if (state == DIV_ZERO) begin
                ready  = 1'b1;
                result = {quo, {REG_W{1'b1}}};
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, destination passthrough and multi-cycle divide with pipeline stall.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   ex_aluop,
    input  logic [ALU_SEL_W-1:0]  ex_alusel,
    input  logic [REG_W-1:0]      ex_reg1,
    input  logic [REG_W-1:0]      ex_reg2,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  whilo_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  stallreq_o
);

    logic               is_div;
    logic [REG_W-1:0]   logic_res, shift_res, arith_res;
    logic [2*REG_W-1:0] div_result;
    logic               div_ready;

    assign is_div = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);

    div u_div (
        .clk        (clk),
        .rst        (rst),
        .signed_div (ex_aluop == OP_DIV),
        .opdata1    (ex_reg1),
        .opdata2    (ex_reg2),
        .start      (is_div),
        .annul      (flush),
        .result     (div_result),
        .ready      (div_ready)
    );

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        unique case (ex_aluop)
            OP_OR:   logic_res = ex_reg1 | ex_reg2;
            OP_AND:  logic_res = ex_reg1 & ex_reg2;
            OP_XOR:  logic_res = ex_reg1 ^ ex_reg2;
            OP_NOR:  logic_res = ~(ex_reg1 | ex_reg2);
            OP_SLL:  shift_res = ex_reg2 << ex_reg1[4:0];
            OP_SRL:  shift_res = ex_reg2 >> ex_reg1[4:0];
            OP_SRA:  shift_res = $unsigned($signed(ex_reg2) >>> ex_reg1[4:0]);
            OP_ADDU: arith_res = ex_reg1 + ex_reg2;
            OP_SUBU: arith_res = ex_reg1 - ex_reg2;
            OP_SLT:  arith_res = {{(REG_W-1){1'b0}}, $signed(ex_reg1) < $signed(ex_reg2)};
            OP_SLTU: arith_res = {{(REG_W-1){1'b0}}, ex_reg1 < ex_reg2};
            default: ;
        endcase
    end

    // Stall holds ID/EX, so the DIV op stays visible until the divider reports ready.
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o       = ex_wd;
            wreg_o     = ex_wreg && !is_div;
            stallreq_o = is_div && !div_ready;
            unique case (ex_alusel)
                SEL_LOGIC: wdata_o = logic_res;
                SEL_SHIFT: wdata_o = shift_res;
                SEL_ARITH: wdata_o = arith_res;
                default:   wdata_o = '0;
            endcase
        end
    end

    assign whilo_o = div_ready;
    assign hi_o    = div_result[2*REG_W-1:REG_W];
    assign lo_o    = div_result[REG_W-1:0];

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1, ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic        flush;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_pass   = 0;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex_aluop   (ex_aluop),
        .ex_alusel  (ex_alusel),
        .ex_reg1    (ex_reg1),
        .ex_reg2    (ex_reg2),
        .ex_wd      (ex_wd),
        .ex_wreg    (ex_wreg),
        .flush      (flush),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int unsigned sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(a % 32);
        case (sel)
            SEL_LOGIC: case (op)
                OP_OR:   return a | b;
                OP_AND:  return a & b;
                OP_XOR:  return a ^ b;
                OP_NOR:  return ~(a | b);
                default: return 32'd0;
            endcase
            SEL_SHIFT: case (op)
                OP_SLL:  return 32'(longint'(b) * (64'd1 << sh));
                OP_SRL:  return 32'(longint'(b) / (64'd1 << sh));
                OP_SRA:  return 32'((sb - ((sb % (64'sd1 <<< sh) + (64'sd1 <<< sh)) % (64'sd1 <<< sh))) / (64'sd1 <<< sh));
                default: return 32'd0;
            endcase
            SEL_ARITH: case (op)
                OP_ADDU: return 32'(longint'(a) + longint'(b));
                OP_SUBU: return 32'(longint'(a) - longint'(b));
                OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
                OP_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_div(input bit is_signed, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = is_signed ? longint'($signed(a)) : longint'({32'd0, a});
        sb = is_signed ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic set_nop();
        ex_aluop  = OP_NOP;
        ex_alusel = SEL_NOP;
        ex_reg1   = $urandom;
        ex_reg2   = $urandom;
        ex_wd     = 5'($urandom);
        ex_wreg   = 1'b0;
    endtask

    task automatic do_alu(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        ex_aluop  = op;
        ex_alusel = sel;
        ex_reg1   = a;
        ex_reg2   = b;
        ex_wd     = 5'($urandom);
        ex_wreg   = 1'($urandom);
        @(negedge clk);
        check($sformatf("alu op=%h a=%h b=%h", op, a, b), {32'd0, wdata_o}, {32'd0, ref_alu(op, sel, a, b)});
        check("alu dest", {58'd0, wreg_o, wd_o}, {58'd0, ex_wreg, ex_wd});
        check("alu stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic issue_div(input bit is_signed, input logic [31:0] a, input logic [31:0] b);
        ex_aluop  = is_signed ? OP_DIV : OP_DIVU;
        ex_alusel = SEL_ARITH;
        ex_reg1   = a;
        ex_reg2   = b;
        ex_wd     = 5'($urandom);
        ex_wreg   = 1'b1;
    endtask

    // Expects to be entered just after a rising edge with the divider idle.
    task automatic run_div(input bit is_signed, input logic [31:0] a, input logic [31:0] b);
        int stall_cnt = 0;
        int whilo_cnt = 0;
        int whilo_at  = -1;
        int lat;
        logic [63:0] got = '0;
        lat = (b == 32'd0) ? 1 : 33;
        issue_div(is_signed, a, b);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) check("div wreg", {63'd0, wreg_o}, 64'd0);
            if (stallreq_o) stall_cnt++;
            if (whilo_o) begin
                whilo_cnt++;
                if (whilo_at < 0) begin
                    whilo_at = k;
                    got = {hi_o, lo_o};
                end
            end
            @(posedge clk); #1;
            if (whilo_at >= 0) set_nop();
            else begin
                ex_reg1 = $urandom;
                ex_reg2 = $urandom;
            end
        end
        check($sformatf("div result s=%0d a=%h b=%h", is_signed, a, b), got, ref_div(is_signed, a, b));
        check("div whilo count", 64'(whilo_cnt), 64'd1);
        check("div latency", 64'(whilo_at), 64'(lat));
        check("div stall cycles", 64'(stall_cnt), 64'(lat));
    endtask

    task automatic watch_quiet(input string tag);
        int whilo_cnt = 0;
        int stall_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (whilo_o) whilo_cnt++;
            if (stallreq_o) stall_cnt++;
        end
        @(posedge clk); #1;
        check({tag, " whilo"}, 64'(whilo_cnt), 64'd0);
        check({tag, " stall"}, 64'(stall_cnt), 64'd0);
    endtask

    logic [7:0] ops  [11] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                              OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU};
    logic [2:0] sels [11] = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_SHIFT, SEL_SHIFT,
                              SEL_SHIFT, SEL_ARITH, SEL_ARITH, SEL_ARITH, SEL_ARITH};

    initial begin
        flush = 1'b0;
        rst   = 1'b1;
        issue_div(1'b1, 32'd100, 32'd7);
        @(negedge clk);
        check("reset stall", {63'd0, stallreq_o}, 64'd0);
        check("reset hilo", {31'd0, whilo_o, hi_o, lo_o}, 64'd0);
        check("reset wb", {26'd0, wd_o, wreg_o, wdata_o}, 64'd0);
        set_nop();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_alu(OP_OR, SEL_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0);
        do_alu(OP_OR, SEL_NOP, 32'h1234_5678, 32'h0F0F_0F0F);
        do_alu(8'hFF, SEL_LOGIC, 32'hFFFF_FFFF, 32'h1);
        do_alu(OP_SRA, SEL_SHIFT, 32'd31, 32'h8000_0000);
        do_alu(OP_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);
        do_alu(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 40; i++) begin
            int unsigned j;
            j = $urandom_range(0, 10);
            do_alu(ops[j], sels[j], $urandom, $urandom);
        end

        run_div(1'b1, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd2);
        run_div(1'b1, 32'd5, 32'd0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] b;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_div(1'($urandom), $urandom, b);
        end

        issue_div(1'b1, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush whilo", {63'd0, whilo_o}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        set_nop();
        watch_quiet("after flush");
        run_div(1'b1, 32'd9, 32'd3);

        issue_div(1'b0, 32'd1000, 32'd3);
        repeat (21) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset hilo", {31'd0, whilo_o, hi_o, lo_o}, 64'd0);
        check("async reset wb", {25'd0, stallreq_o, wd_o, wreg_o, wdata_o}, 64'd0);
        set_nop();
        @(posedge clk); #1;
        rst = 1'b0;
        watch_quiet("after reset");
        run_div(1'b0, 32'd1000, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
